uart_tx: RTL and testbench

- 8-bit asynchronous serial transmitter, clocked from the 48.6 MHz UART PLL output.
- Accepts bytes over a valid/ready handshake and shifts them out LSB-first on `tx`: start bit, 8 data bits, optional parity, then stop bit(s).
- Bit timing comes from a fractional phase accumulator, so a non-integer CLOCK_HZ/BAUD ratio (421.875 at defaults) is produced with no long-term drift.
- Companion to the existing UART receive path; drives the board's serial TX pin.

---
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with fractional-baud phase accumulator
// Optional parity bit after data bit 7 when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLOCK_HZ   = 48600000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       tx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       ODD      = (PARITY_ODD != 0);
`endif

  localparam logic [31:0] CLOCK_W   = 32'(CLOCK_HZ);
  localparam logic [31:0] BAUD_W    = 32'(BAUD);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      CLOCK_HZ < 2 * BAUD) begin : g_param_check
    $error("uart_tx: illegal parameter combination");
  end

  logic [2:0]  state;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic        tick;
`ifdef UART_TX_PARITY_EN
  logic        parity;
`endif

  // acc stays below CLOCK_HZ and BAUD <= CLOCK_HZ/2, so the sum cannot wrap 32 bits
  always_comb begin
    acc_sum = acc + BAUD_W;
    tick    = (acc_sum >= CLOCK_W);
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      acc      <= 32'd0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        state    <= S_START;
        shreg    <= in_data;
        bit_cnt  <= 3'd0;
        stop_cnt <= 1'b0;
        acc      <= 32'd0;
        tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity   <= (^in_data) ^ ODD;
`endif
      end
    end else begin
      acc <= tick ? (acc_sum - CLOCK_W) : acc_sum;
      if (tick) begin
        case (state)
          S_START: begin
            state   <= S_DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= 3'd0;
          end
          S_DATA: begin
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end else begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
`endif
          S_STOP: begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx
// Expected line waveform is derived from the frame-bit timing formula.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam longint CA   = 48600000;
  localparam longint BA   = 115200;
  localparam longint CB   = 8;
  localparam longint BB   = 2;
  localparam int     PODD = 0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_ready, a_busy, a_tx;
  logic       b_valid, b_ready, b_busy, b_tx;

  int checks = 0;
  int errors = 0;

  logic tr [0:9000];
  logic rd [0:9000];
  logic bs [0:9000];

  uart_tx dut_a (
    .clock(clock), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .busy(a_busy), .tx(a_tx)
  );

  uart_tx #(.CLOCK_HZ(8), .BAUD(2), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .busy(b_busy), .tx(b_tx)
  );

  always #5 clock = ~clock;

  function automatic int nbits(int stop);
`ifdef UART_TX_PARITY_EN
    return 10 + stop;
`else
    return 9 + stop;
`endif
  endfunction

  function automatic logic [11:0] frame_of(logic [7:0] b);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = (^b) ^ (PODD != 0);
`endif
    return f;
  endfunction

  // first cycle of frame bit k, counted from the accept cycle
  function automatic longint bstart(int k, longint cl, longint bd);
    return 1 + (k * cl + bd - 1) / bd;
  endfunction

  function automatic int frame_end(longint cl, longint bd, int n);
    return int'(bstart(n, cl, bd));
  endfunction

  function automatic logic exp_tx(int c, longint cl, longint bd, int n, logic [11:0] fr);
    for (int k = 0; k < n; k++)
      if (c >= bstart(k, cl, bd) && c < bstart(k + 1, cl, bd)) return fr[k];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Records outputs for cycles 0..ncyc; cycle 0 is the cycle the caller raised in_valid.
  task automatic capture(input int sel, input int ncyc, input int drop,
                         input int c1, input logic [7:0] v1,
                         input int c2, input logic [7:0] v2, input int rst);
    for (int c = 0; c <= ncyc; c++) begin
      reset_n = (c != rst);
      if (c == c1 || c == c2) begin
        if (sel == 0) a_data = (c == c1) ? v1 : v2;
        else          b_data = (c == c1) ? v1 : v2;
      end
      tr[c] = (sel == 0) ? a_tx    : b_tx;
      rd[c] = (sel == 0) ? a_ready : b_ready;
      bs[c] = (sel == 0) ? a_busy  : b_busy;
      if (c < ncyc) begin
        step();
        if (c + 1 >= drop) begin
          if (sel == 0) a_valid = 1'b0;
          else          b_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    int n = nbits(1);
    int e = frame_end(CA, BA, n);
    logic [11:0] fr = frame_of(8'hFF);
    reset_n = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_tx !== 1'b1)    begin errors++; $display("FAIL rst_tx i=%0d got %b exp 1", i, a_tx); end
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready i=%0d got %b exp 1", i, a_ready); end
      checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy i=%0d got %b exp 0", i, a_busy); end
    end
    capture(0, e + 2, 1, -1, 8'h00, -1, 8'h00, -1);
    checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", rd[0]); end
    checks++; if (tr[1] !== 1'b0) begin errors++; $display("FAIL rst_release_start got %b exp 0", tr[1]); end
    for (int c = 1; c <= e + 2; c++) begin
      checks++; if (tr[c] !== exp_tx(c, CA, BA, n, fr)) begin errors++; $display("FAIL rst_frame_tx c=%0d got %b exp %b", c, tr[c], exp_tx(c, CA, BA, n, fr)); end
      checks++; if (rd[c] !== (c >= e)) begin errors++; $display("FAIL rst_frame_ready c=%0d got %b exp %b", c, rd[c], (c >= e)); end
    end
  endtask

  task automatic test_frame_55();
    int n = nbits(1);
    int e = frame_end(CA, BA, n);
    logic [11:0] fr = frame_of(8'h55);
    int edges[$];
    int exp_edges[10] = '{1, 423, 845, 1267, 1689, 2111, 2533, 2955, 3376, 3798};
    int rise = -1;
    a_data  = 8'h55;
    a_valid = 1'b1;
    capture(0, e + 2, 1, -1, 8'h00, -1, 8'h00, -1);
    for (int c = 1; c <= e + 2; c++) begin
      checks++; if (tr[c] !== exp_tx(c, CA, BA, n, fr)) begin errors++; $display("FAIL f55_tx c=%0d got %b exp %b", c, tr[c], exp_tx(c, CA, BA, n, fr)); end
      checks++; if (rd[c] !== (c >= e)) begin errors++; $display("FAIL f55_ready c=%0d got %b exp %b", c, rd[c], (c >= e)); end
      checks++; if (bs[c] !== (c < e))  begin errors++; $display("FAIL f55_busy c=%0d got %b exp %b", c, bs[c], (c < e)); end
      if (tr[c] !== tr[c - 1]) edges.push_back(c);
      if (rise < 0 && rd[c] === 1'b1) rise = c;
    end
`ifndef UART_TX_PARITY_EN
    checks++; if (rise != 4220) begin errors++; $display("FAIL f55_rise got %0d exp 4220", rise); end
    checks++;
    if (edges.size() != 10) begin
      errors++; $display("FAIL f55_edge_count got %0d exp 10", edges.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (edges[i] != exp_edges[i]) begin errors++; $display("FAIL f55_edge%0d got %0d exp %0d", i, edges[i], exp_edges[i]); end
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] b = 8'($urandom);
      int gap = $urandom_range(0, 3);
      int n = nbits(1);
      int e = frame_end(CA, BA, n);
      logic [11:0] fr = frame_of(b);
      a_data  = b;
      a_valid = 1'b1;
      capture(0, e + gap, 1, -1, 8'h00, -1, 8'h00, -1);
      for (int c = 1; c <= e + gap; c++) begin
        checks++; if (tr[c] !== exp_tx(c, CA, BA, n, fr)) begin errors++; $display("FAIL rand_tx byte=%02h c=%0d got %b exp %b", b, c, tr[c], exp_tx(c, CA, BA, n, fr)); end
        checks++; if (rd[c] !== (c >= e)) begin errors++; $display("FAIL rand_ready byte=%02h c=%0d got %b exp %b", b, c, rd[c], (c >= e)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = nbits(1);
    int e = frame_end(CA, BA, n);
    logic [11:0] fa = frame_of(8'hA3);
    logic [11:0] fb = frame_of(8'h0F);
    logic ex, er;
    a_data  = 8'hA3;
    a_valid = 1'b1;
    capture(0, 2 * e, e + 1, 100, 8'h00, 4000, 8'h0F, -1);
    for (int c = 1; c <= 2 * e; c++) begin
      ex = (c < e) ? exp_tx(c, CA, BA, n, fa) : exp_tx(c - e, CA, BA, n, fb);
      er = (c == e) || (c >= 2 * e);
      checks++; if (tr[c] !== ex) begin errors++; $display("FAIL b2b_tx c=%0d got %b exp %b", c, tr[c], ex); end
      checks++; if (rd[c] !== er) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, rd[c], er); end
    end
`ifndef UART_TX_PARITY_EN
    checks++; if (rd[4220] !== 1'b1) begin errors++; $display("FAIL b2b_accept4220 got %b exp 1", rd[4220]); end
    checks++; if (tr[4221] !== 1'b0) begin errors++; $display("FAIL b2b_start4221 got %b exp 0", tr[4221]); end
`endif
  endtask

  task automatic test_reset_mid();
    int n = nbits(1);
    int e = frame_end(CA, BA, n);
    logic [11:0] f0 = frame_of(8'h00);
    logic [11:0] f1 = frame_of(8'h81);
    logic ex;
    int w = 0;
    a_data  = 8'h00;
    a_valid = 1'b1;
    capture(0, 2003, 1, -1, 8'h00, -1, 8'h00, 2000);
    for (int c = 1; c <= 2003; c++) begin
      ex = (c <= 2000) ? exp_tx(c, CA, BA, n, f0) : 1'b1;
      checks++; if (tr[c] !== ex) begin errors++; $display("FAIL rmid_tx c=%0d got %b exp %b", c, tr[c], ex); end
      checks++; if (rd[c] !== (c > 2000)) begin errors++; $display("FAIL rmid_ready c=%0d got %b exp %b", c, rd[c], (c > 2000)); end
    end
    a_data  = 8'h81;
    a_valid = 1'b1;
    capture(0, e + 1, 1, -1, 8'h00, -1, 8'h00, -1);
    for (int c = 1; c <= e + 1; c++) begin
      checks++; if (tr[c] !== exp_tx(c, CA, BA, n, f1)) begin errors++; $display("FAIL rmid_next_tx c=%0d got %b exp %b", c, tr[c], exp_tx(c, CA, BA, n, f1)); end
    end
    for (int c = 1; c < 1000 && tr[c] === 1'b0; c++) w++;
    checks++; if (w != 422) begin errors++; $display("FAIL rmid_start_width got %0d exp 422", w); end
    checks++; if (tr[423] !== 1'b1) begin errors++; $display("FAIL rmid_first_data got %b exp 1", tr[423]); end
  endtask

  task automatic test_small_ratio();
    int n = nbits(2);
    int e = frame_end(CB, BB, n);
    logic [11:0] fr = frame_of(8'h3C);
    int rise = -1;
    b_data  = 8'h3C;
    b_valid = 1'b1;
    capture(1, e + 2, 1, -1, 8'h00, -1, 8'h00, -1);
    for (int c = 1; c <= e + 2; c++) begin
      checks++; if (tr[c] !== exp_tx(c, CB, BB, n, fr)) begin errors++; $display("FAIL small_tx c=%0d got %b exp %b", c, tr[c], exp_tx(c, CB, BB, n, fr)); end
      checks++; if (rd[c] !== (c >= e)) begin errors++; $display("FAIL small_ready c=%0d got %b exp %b", c, rd[c], (c >= e)); end
      if (rise < 0 && rd[c] === 1'b1) rise = c;
    end
`ifndef UART_TX_PARITY_EN
    checks++; if (rise != 45) begin errors++; $display("FAIL small_rise got %0d exp 45", rise); end
`endif
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic pexp = 1'b1 ^ (PODD != 0);
    a_data  = 8'h07;
    a_valid = 1'b1;
    capture(0, 4643, 1, -1, 8'h00, -1, 8'h00, -1);
    for (int c = 3798; c < 4642; c++) begin
      checks++; if (tr[c] !== ((c < 4220) ? pexp : 1'b1)) begin errors++; $display("FAIL par_tx c=%0d got %b exp %b", c, tr[c], ((c < 4220) ? pexp : 1'b1)); end
    end
    checks++; if (rd[4641] !== 1'b0) begin errors++; $display("FAIL par_ready4641 got %b exp 0", rd[4641]); end
    checks++; if (rd[4642] !== 1'b1) begin errors++; $display("FAIL par_ready4642 got %b exp 1", rd[4642]); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = 8'h00;
    b_data  = 8'h00;
    test_reset();
    test_frame_55();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_small_ratio();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
